// File: rtl/piso_pkg.sv
// piso_pkg
// Shared defaults for the 32-bit parallel-in serial-out shift register core.
//   PISO_DEFAULT_WIDTH    : default shift register width (32)
//   PISO_DEFAULT_FILL_BIT : default bit shifted into the vacated end
//   piso_count_width()    : bits needed to count 0..width shifts inclusive
//   piso_count_t          : shift count type sized for the default width
package piso_pkg;

  localparam int   PISO_DEFAULT_WIDTH    = 32;
  localparam logic PISO_DEFAULT_FILL_BIT = 1'b0;

  // The count must be able to hold the value 'width' itself, hence width+1.
  function automatic int piso_count_width(input int width);
    return $clog2(width + 1);
  endfunction

  typedef logic [piso_count_width(PISO_DEFAULT_WIDTH)-1:0] piso_count_t;

endpackage

// File: rtl/piso_shift_counter.sv
// piso_shift_counter
// Counts shifts since the last load or reset, saturating at DATA_WIDTH.
// Only instantiated when PISO_SHIFT_STATUS_EN is defined.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high clear
//   load  : clears the count (a new word was captured)
//   shift : one shift happened at this edge
//   count : shifts since load/reset, saturates at DATA_WIDTH
//   done  : high when count equals DATA_WIDTH (word fully emitted)
module piso_shift_counter
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = PISO_DEFAULT_WIDTH,
  parameter int CNT_W      = piso_count_width(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] CountMax = CNT_W'(DATA_WIDTH);

  // Saturate rather than wrap so 'done' stays asserted while the
  // register keeps draining fill bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (shift && (count != CountMax)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == CountMax);

endmodule

// File: rtl/parallel_in_serial_out_piso_32_bit_core.sv
// parallel_in_serial_out_piso_32_bit_core
// Parallel-in serial-out shift register. Priority per edge: reset, load, shift.
// Optional status outputs are enabled by defining PISO_SHIFT_STATUS_EN.
// Ports:
//   Clk_In              : clock, all state updates on the rising edge
//   Reset_In            : synchronous active-high reset, clears register to 0
//   Load_Shiftb_In      : 1 = parallel load, 0 = shift one position
//   Parallel_Data_In    : word captured on a load
//   Serial_Data_Out     : bit at the output end of the register (combinational)
//   PISO_Shift_Register : current register contents
//   Shift_Count_Out     : (PISO_SHIFT_STATUS_EN) shifts since load, saturating
//   Word_Done_Out       : (PISO_SHIFT_STATUS_EN) high when all bits emitted
module parallel_in_serial_out_piso_32_bit_core
  import piso_pkg::*;
#(
  parameter int   DATA_WIDTH = PISO_DEFAULT_WIDTH,
  parameter logic FILL_BIT   = PISO_DEFAULT_FILL_BIT,
  parameter bit   MSB_FIRST  = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Load_Shiftb_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic                  Serial_Data_Out,
  output logic [DATA_WIDTH-1:0] PISO_Shift_Register
`ifdef PISO_SHIFT_STATUS_EN
  ,
  output logic [piso_count_width(DATA_WIDTH)-1:0] Shift_Count_Out,
  output logic                                    Word_Done_Out
`endif
);

  logic [DATA_WIDTH-1:0] shift_reg;

  // Reset always clears to zero, independent of FILL_BIT, so the serial
  // output is 0 after reset in every configuration.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      shift_reg <= '0;
    end else if (Load_Shiftb_In) begin
      shift_reg <= Parallel_Data_In;
    end else if (MSB_FIRST) begin
      shift_reg <= {shift_reg[DATA_WIDTH-2:0], FILL_BIT};
    end else begin
      shift_reg <= {FILL_BIT, shift_reg[DATA_WIDTH-1:1]};
    end
  end

  assign PISO_Shift_Register = shift_reg;
  assign Serial_Data_Out     = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];

`ifdef PISO_SHIFT_STATUS_EN
  piso_shift_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift_counter (
    .clk  (Clk_In),
    .reset(Reset_In),
    .load (Load_Shiftb_In),
    .shift(~Load_Shiftb_In),
    .count(Shift_Count_Out),
    .done (Word_Done_Out)
  );
`endif

endmodule

// File: tb/tb_parallel_in_serial_out_piso_32_bit_core.sv
// tb_parallel_in_serial_out_piso_32_bit_core
// Self-checking bench for the default configuration (32 bits, fill 0,
// MSB first). A word/shift-count model predicts the register every cycle;
// directed scenarios add literal expectations. Define PISO_SHIFT_STATUS_EN
// to also check the status outputs.
module tb_parallel_in_serial_out_piso_32_bit_core;

  logic        clk = 1'b0;
  logic        resetIn = 1'b0;
  logic        loadIn = 1'b0;
  logic [31:0] dataIn = '0;
  logic        serialOut;
  logic [31:0] regOut;
`ifdef PISO_SHIFT_STATUS_EN
  logic [5:0]  countOut;
  logic        doneOut;
`endif

  int nChecks = 0;
  int nPass   = 0;

  // Model: last captured word plus the number of shifts since capture.
  logic [31:0] mWord = '0;
  int          mShifts = 0;
  bit          mValid = 1'b0;

  parallel_in_serial_out_piso_32_bit_core dut (
    .Clk_In             (clk),
    .Reset_In           (resetIn),
    .Load_Shiftb_In     (loadIn),
    .Parallel_Data_In   (dataIn),
    .Serial_Data_Out    (serialOut),
    .PISO_Shift_Register(regOut)
`ifdef PISO_SHIFT_STATUS_EN
    ,
    .Shift_Count_Out    (countOut),
    .Word_Done_Out      (doneOut)
`endif
  );

  always #5 clk = ~clk;

  // Register content implied by the model: the word moved left by the
  // number of shifts, zero once every bit has been pushed out.
  function automatic logic [31:0] expectedReg();
    if (mShifts >= 32) return 32'h0;
    return mWord << mShifts;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle.
  task automatic applyStimulus(input logic r, input logic l, input logic [31:0] d);
    resetIn = r;
    loadIn  = l;
    dataIn  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic shiftN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom);
  endtask

  // Model update at each rising edge: reset beats load beats shift.
  always @(posedge clk) begin
    if (resetIn) begin
      mWord   = 32'h0;
      mShifts = 0;
      mValid  = 1'b1;
    end else if (loadIn) begin
      mWord   = dataIn;
      mShifts = 0;
      mValid  = 1'b1;
    end else if (mShifts < 40) begin
      mShifts = mShifts + 1;
    end
  end

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("model_reg", 64'(regOut), 64'(expectedReg()));
      checkOutput("model_serial", 64'(serialOut), 64'(expectedReg() >> 31));
`ifdef PISO_SHIFT_STATUS_EN
      checkOutput("model_count", 64'(countOut), 64'((mShifts > 32) ? 32 : mShifts));
      checkOutput("model_done", 64'(doneOut), 64'(mShifts >= 32));
`endif
    end
  end

  initial begin
    logic [31:0] collected;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("reset_reg", 64'(regOut), 64'h0);
    checkOutput("reset_serial", 64'(serialOut), 64'h0);

    // Scenario 1: 0x80000001 emitted MSB first -> 1, thirty 0s, 1
    applyStimulus(1'b0, 1'b1, 32'h80000001);
    collected = '0;
    for (int i = 0; i < 32; i++) begin
      collected[31-i] = serialOut;
      applyStimulus(1'b0, 1'b0, $urandom);
    end
    checkOutput("s1_serial_stream", 64'(collected), 64'h80000001);

    // Scenario 2: drain all ones, stays zero past 32 shifts
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);
    shiftN(31);
    checkOutput("s2_reg_after31", 64'(regOut), 64'h80000000);
    shiftN(1);
    checkOutput("s2_reg_after32", 64'(regOut), 64'h0);
    shiftN(3);
    checkOutput("s2_reg_after35", 64'(regOut), 64'h0);

    // Scenario 3: reload mid-stream
    applyStimulus(1'b0, 1'b1, 32'hA5A5A5A5);
    shiftN(5);
    checkOutput("s3_reg_after5", 64'(regOut), 64'hB4B4B4A0);
    applyStimulus(1'b0, 1'b1, 32'h12345678);
    checkOutput("s3_reload_reg", 64'(regOut), 64'h12345678);
    checkOutput("s3_first_bit", 64'(serialOut), 64'h0);
    shiftN(3);
    checkOutput("s3_after3", 64'(regOut), 64'h91A2B3C0);
    checkOutput("s3_bit3", 64'(serialOut), 64'h1);

    // Scenario 4: reset wins over a simultaneous load
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF);
    checkOutput("s4_reg", 64'(regOut), 64'h0);
    checkOutput("s4_serial", 64'(serialOut), 64'h0);

    // Scenario 5: reset mid-shift discards the rest of the word
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);
    shiftN(10);
    checkOutput("s5_before_reset", 64'(regOut), 64'hFFFFFC00);
    applyStimulus(1'b1, 1'b0, $urandom);
    checkOutput("s5_after_reset", 64'(regOut), 64'h0);
    shiftN(4);
    checkOutput("s5_shift_after_reset", 64'(regOut), 64'h0);
    checkOutput("s5_serial", 64'(serialOut), 64'h0);

`ifdef PISO_SHIFT_STATUS_EN
    // Scenario 6: status counter saturates at 32
    applyStimulus(1'b0, 1'b1, $urandom);
    checkOutput("s6_count_load", 64'(countOut), 64'd0);
    shiftN(32);
    checkOutput("s6_count32", 64'(countOut), 64'd32);
    checkOutput("s6_done", 64'(doneOut), 64'd1);
    shiftN(1);
    checkOutput("s6_count33", 64'(countOut), 64'd32);
`endif

    // Randomized traffic, checked by the continuous model comparison
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, $urandom);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
